// File: rtl/avg_pkg.sv
// Shared phase enumeration, widths and microstate decode for the vector state sequencer.
package avg_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned ADDR_W  = 1 + OP_W + STATE_W;
  localparam int unsigned WAIT_W  = 12;

  // Microstate bit positions and the halt pattern held in the top two bits.
  localparam int unsigned BIT_PC_INC   = 0;
  localparam int unsigned BIT_LATCH_OP = 1;
  localparam int unsigned BIT_DRAW     = 2;
  localparam int unsigned BIT_HALT     = 3;
  localparam logic [1:0]  HALT_PAT     = 2'b11;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_ADDR    = 3'd1,
    PH_CAPTURE = 3'd2,
    PH_EXEC    = 3'd3,
    PH_WAIT    = 3'd4
  } phase_e;

  // Top two microstate bits equal to the halt pattern stop the sequencer.
  function automatic logic is_halt(input logic [STATE_W-1:0] s);
    return s[BIT_HALT -: 2] == HALT_PAT;
  endfunction

  // A draw starts only when the draw bit is set outside the halt pattern.
  function automatic logic is_draw(input logic [STATE_W-1:0] s);
    return s[BIT_DRAW] & ~s[BIT_HALT];
  endfunction

endpackage

// File: rtl/avg_wait_timer.sv
// Counts WAIT cycles and flags the first cycle and the cycle that reaches the limit.
module avg_wait_timer
  import avg_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 4095
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic first_o,
  output logic last_o
);

  localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(WAIT_LIMIT - 1);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;
  logic              first_q;
  logic              last_q;
  logic              last_d;

  // Next count; last flags the WAIT cycle whose count completes the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
    last_d = (clear_i | en_i) & (cnt_d == LAST_CNT);
  end

  // Counter and flag registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= clear_i;
      last_q  <= last_d;
    end
  end

  assign first_o = first_q;
  assign last_o  = last_q;

endmodule

// File: rtl/avg_state_sequencer.sv
// Microcoded vector state sequencer stepping through an external 256x4 state PROM.
module avg_state_sequencer
  import avg_pkg::*;
#(
  parameter int unsigned        WAIT_LIMIT  = 4095,
  parameter logic [STATE_W-1:0] START_STATE = 4'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               stop_req,
  input  logic [OP_W-1:0]    op,
  input  logic               draw_busy,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_cs,
  input  logic [STATE_W-1:0] rom_dout,
  output logic               pc_inc,
  output logic               latch_op,
  output logic               start_draw,
  output logic               halted,
  output logic               timeout,
  output logic [STATE_W-1:0] state
);

  phase_e             phase_q;
  logic [STATE_W-1:0] state_q;
  logic               rom_cs_q;
  logic               pc_inc_q;
  logic               latch_op_q;
  logic               start_draw_q;
  logic               halted_q;
  logic               timeout_q;
  logic               exec_halt_c;
  logic               wait_enter_c;
  logic               wait_first;
  logic               wait_last;

  // EXEC exit decisions: halt/stop first, then a draw enters WAIT.
  assign exec_halt_c  = is_halt(state_q) | stop_req;
  assign wait_enter_c = (phase_q == PH_EXEC) & ~exec_halt_c & start_draw_q;

  avg_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (wait_enter_c),
    .en_i    (phase_q == PH_WAIT),
    .first_o (wait_first),
    .last_o  (wait_last)
  );

  // Phase machine; pulses and the PROM select are registered on the transition into their phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= PH_IDLE;
      state_q      <= START_STATE;
      rom_cs_q     <= 1'b0;
      pc_inc_q     <= 1'b0;
      latch_op_q   <= 1'b0;
      start_draw_q <= 1'b0;
      halted_q     <= 1'b1;
      timeout_q    <= 1'b0;
    end else begin
      rom_cs_q     <= 1'b0;
      pc_inc_q     <= 1'b0;
      latch_op_q   <= 1'b0;
      start_draw_q <= 1'b0;
      unique case (phase_q)
        PH_IDLE: begin
          if (go) begin
            state_q   <= START_STATE;
            timeout_q <= 1'b0;
            halted_q  <= 1'b0;
            rom_cs_q  <= 1'b1;
            phase_q   <= PH_ADDR;
          end
        end
        PH_ADDR: begin
          phase_q <= PH_CAPTURE;
        end
        PH_CAPTURE: begin
          state_q      <= rom_dout;
          pc_inc_q     <= rom_dout[BIT_PC_INC];
          latch_op_q   <= rom_dout[BIT_LATCH_OP];
          start_draw_q <= is_draw(rom_dout);
          phase_q      <= PH_EXEC;
        end
        PH_EXEC: begin
          if (exec_halt_c) begin
            halted_q <= 1'b1;
            phase_q  <= PH_IDLE;
          end else if (start_draw_q) begin
            phase_q <= PH_WAIT;
          end else begin
            rom_cs_q <= 1'b1;
            phase_q  <= PH_ADDR;
          end
        end
        PH_WAIT: begin
          // A finished draw takes precedence over a timeout landing in the same cycle.
          if (!wait_first && !draw_busy) begin
            rom_cs_q <= 1'b1;
            phase_q  <= PH_ADDR;
          end else if (wait_last) begin
            timeout_q <= 1'b1;
            halted_q  <= 1'b1;
            phase_q   <= PH_IDLE;
          end
        end
        default: begin
          halted_q <= 1'b1;
          phase_q  <= PH_IDLE;
        end
      endcase
    end
  end

  // The PROM page bit tracks the select; op is passed straight through.
  assign rom_addr   = {rom_cs_q, op, state_q};
  assign rom_cs     = rom_cs_q;
  assign pc_inc     = pc_inc_q;
  assign latch_op   = latch_op_q;
  assign start_draw = start_draw_q;
  assign halted     = halted_q;
  assign timeout    = timeout_q;
  assign state      = state_q;

endmodule

// File: doc/avg_state_sequencer.md
AVG_STATE_SEQUENCER -- requirements
Module: avg_state_sequencer

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- WAIT_LIMIT, 4095, maximum WAIT cycles before timeout.
- START_STATE, 4'h0, state loaded on go.

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- reset, in, 1, asynchronous, active-high.
- go, in, 1, start pulse.
- stop_req, in, 1, soft halt request.
- op, in, 3, current instruction opcode.
- draw_busy, in, 1, vector draw in progress.
- rom_addr, out, 8, address to the 256x4 state PROM.
- rom_cs, out, 1, PROM select.
- rom_dout, in, 4, PROM data; registered, 1-cycle latency.
- pc_inc, out, 1, program-counter increment pulse.
- latch_op, out, 1, latch opcode pulse.
- start_draw, out, 1, draw start pulse.
- halted, out, 1, sequencer idle.
- timeout, out, 1, sticky draw-timeout flag.
- state, out, 4, current microstate (debug).

Function
REQ-003 Phases SHALL be IDLE, ADDR, CAPTURE, EXEC and WAIT, as an enumerated type.
REQ-004 In IDLE, halted SHALL be 1 and rom_cs SHALL be 0. A go pulse SHALL load state<=START_STATE, clear timeout, and move to ADDR.
REQ-005 In ADDR, the block SHALL drive rom_cs=1 and rom_addr={1'b1, op, state}, then move to CAPTURE. In every other phase rom_addr SHALL be {1'b0, op, state}.
REQ-006 In CAPTURE, the block SHALL load state<=rom_dout, then move to EXEC.
REQ-007 EXEC SHALL last exactly one cycle and decode the new state:
- pc_inc=state[0].
- latch_op=state[1].
- start_draw=state[2]&~state[3].
- halt condition: state[3:2]==2'b11.
REQ-008 The three pulses SHALL be asserted only in EXEC and SHALL be exactly 1 cycle wide.
REQ-009 Exit from EXEC SHALL be decided in this priority order:
- halt condition or stop_req -> IDLE.
- start_draw -> WAIT.
- otherwise -> ADDR.
REQ-010 The unstalled step period SHALL therefore be 3 cycles, with go-to-first-pulse latency of 3 cycles.
REQ-011 WAIT SHALL ignore draw_busy in its first cycle. It SHALL return to ADDR on the first later cycle where draw_busy=0.
REQ-012 A 12-bit wait counter SHALL clear on WAIT entry and increment each WAIT cycle. On reaching WAIT_LIMIT, the block SHALL set timeout=1 (sticky) and go to IDLE.
REQ-013 go SHALL be ignored in every phase except IDLE.
REQ-014 stop_req SHALL be sampled only in EXEC; it SHALL never abort ADDR, CAPTURE or WAIT.
REQ-015 If go and stop_req are asserted in the same cycle in IDLE, go SHALL win.
REQ-016 State wrap SHALL be defined by the PROM contents only; the block SHALL apply no arithmetic to state.

Reset
REQ-017 While reset=1 and immediately after reset, the outputs SHALL hold these values, regardless of the phase reset interrupted:
- phase=IDLE, state=START_STATE, halted=1, timeout=0.
- rom_cs=0, rom_addr={1'b0, 3'b000-or-op, START_STATE} with op passed through.
- pc_inc=latch_op=start_draw=0.

Structure
REQ-018 The phase enumeration, the decode bit positions and the halt pattern 2'b11 SHALL live in a shared package, avg_pkg.
REQ-019 The PROM SHALL be external; the sequencer SHALL contain no ROM contents.
REQ-020 The WAIT timeout counter SHALL be a sub-module, avg_wait_timer.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response), using a bench ROM model with 1-cycle latency:
- go with op=0 and ROM[0x80]=4'h3 -> rom_cs at cycle 1; pc_inc=latch_op=1 at cycle 3; ADDR again at cycle 4.
- ROM returns 4'h4 and draw_busy is held for 10 cycles -> start_draw is a single pulse; WAIT lasts 11 cycles; ADDR follows draw_busy falling.
- ROM returns 4'hC -> halted=1 the cycle after EXEC, with no pc_inc.
- draw_busy stuck high with WAIT_LIMIT=16 -> timeout=1 and halted=1 after 16 WAIT cycles; the next go clears timeout.
- stop_req asserted in CAPTURE and held through EXEC -> IDLE after EXEC; go pulses during ADDR and CAPTURE have no effect.
- reset asserted asynchronously in WAIT -> all outputs match REQ-017 within the same cycle, with no spurious pulse.
